// File: rtl/fiber_pe_arbiter.sv
// Round-robin arbiter from NUM_PE processing-element request ports onto the single fiberBank
// request port, with an in-order tag FIFO that steers response beats back to the issuing PE.
module fiber_pe_arbiter #(
   parameter int          NUM_PE     = 4,
   parameter int          DATA_WIDTH = 16,
   parameter int          ADDR_WIDTH = 64,
   parameter int          TAG_DEPTH  = 8,
   parameter logic [15:0] RESP_MASK  = 16'h0006
) (
   input  logic                           i_clk,
   input  logic                           i_nreset,
   input  logic [NUM_PE-1:0]              i_pe_req_valid,
   input  logic [NUM_PE*4-1:0]            i_pe_req_type,
   input  logic [NUM_PE*ADDR_WIDTH-1:0]   i_pe_req_addr,
   input  logic [NUM_PE*DATA_WIDTH-1:0]   i_pe_req_data,
   output logic [NUM_PE-1:0]              o_pe_req_ready,
   output logic [3:0]                     o_request_type,
   output logic [ADDR_WIDTH-1:0]          o_addr,
   output logic [DATA_WIDTH-1:0]          o_data,
   output logic                           o_type_valid,
   input  logic                           i_type_ready,
   input  logic [DATA_WIDTH-1:0]          i_bank_data,
   input  logic                           i_bank_data_valid,
   output logic                           o_bank_data_ready,
   output logic [DATA_WIDTH-1:0]          o_pe_resp_data,
   output logic [NUM_PE-1:0]              o_pe_resp_valid,
   input  logic [NUM_PE-1:0]              i_pe_resp_ready,
   output logic [$clog2(TAG_DEPTH):0]     o_tags_pending,
   output logic                           o_err_orphan
);

   localparam int PW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
   localparam int TW = $clog2(TAG_DEPTH);
   localparam int CW = TW + 1;

   // Every port pair here is valid/ready: a transfer happens in a cycle where both are high,
   // and a producer holding valid keeps its payload unchanged until that cycle.

   logic [3:0]            pe_type [NUM_PE];
   logic [ADDR_WIDTH-1:0] pe_addr [NUM_PE];
   logic [DATA_WIDTH-1:0] pe_data [NUM_PE];

   for (genvar k = 0; k < NUM_PE; k++) begin : g_unpack
      assign pe_type[k] = i_pe_req_type[4*k +: 4];
      assign pe_addr[k] = i_pe_req_addr[ADDR_WIDTH*k +: ADDR_WIDTH];
      assign pe_data[k] = i_pe_req_data[DATA_WIDTH*k +: DATA_WIDTH];
   end

   logic                  out_valid_q;
   logic [3:0]            out_type_q;
   logic [ADDR_WIDTH-1:0] out_addr_q;
   logic [DATA_WIDTH-1:0] out_data_q;
   logic [PW-1:0]         rr_ptr_q;
   logic [PW-1:0]         tag_mem_q [TAG_DEPTH];
   logic [TW-1:0]         wr_ptr_q;
   logic [TW-1:0]         rd_ptr_q;
   logic [CW-1:0]         count_q;
   logic                  err_q;

   logic                  slot_free;
   logic                  room;
   logic                  fifo_empty;
   logic [NUM_PE-1:0]     eligible;
   logic                  grant_valid;
   logic [PW-1:0]         grant_idx;
   logic [PW-1:0]         head;
   logic                  push;
   logic                  pop;
   int                    cand;

   assign slot_free  = !out_valid_q || i_type_ready;
   // Room is judged on the registered count only, so a pop in this cycle cannot admit a push.
   assign room       = count_q < CW'(TAG_DEPTH);
   assign fifo_empty = (count_q == '0);
   assign head       = tag_mem_q[rd_ptr_q];

   always_comb begin
      eligible = '0;
      for (int k = 0; k < NUM_PE; k++) begin
         eligible[k] = i_pe_req_valid[k] && (!RESP_MASK[pe_type[k]] || room);
      end
   end

   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      for (int i = 1; i <= NUM_PE; i++) begin
         cand = (int'(rr_ptr_q) + i) % NUM_PE;
         if (!grant_valid && eligible[cand[PW-1:0]]) begin
            grant_valid = 1'b1;
            grant_idx   = cand[PW-1:0];
         end
      end
      if (!slot_free || !i_nreset) begin
         grant_valid = 1'b0;
      end
   end

   always_comb begin
      o_pe_req_ready = '0;
      if (grant_valid) begin
         o_pe_req_ready[grant_idx] = 1'b1;
      end
   end

   assign push = grant_valid && RESP_MASK[pe_type[grant_idx]];

   always_comb begin
      o_pe_resp_valid = '0;
      if (!fifo_empty) begin
         o_pe_resp_valid[head] = i_bank_data_valid;
      end
   end

   assign o_bank_data_ready = !fifo_empty && i_pe_resp_ready[head];
   assign pop               = i_bank_data_valid && o_bank_data_ready;
   assign o_pe_resp_data    = i_bank_data;

   always_ff @(posedge i_clk or negedge i_nreset) begin
      if (!i_nreset) begin
         out_valid_q <= 1'b0;
         out_type_q  <= '0;
         out_addr_q  <= '0;
         out_data_q  <= '0;
         rr_ptr_q    <= PW'(NUM_PE - 1);
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         if (slot_free) begin
            out_valid_q <= grant_valid;
         end
         if (grant_valid) begin
            out_type_q <= pe_type[grant_idx];
            out_addr_q <= pe_addr[grant_idx];
            out_data_q <= pe_data[grant_idx];
            rr_ptr_q   <= grant_idx;
         end
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (push && !pop) begin
            count_q <= count_q + 1'b1;
         end else if (pop && !push) begin
            count_q <= count_q - 1'b1;
         end
         if (fifo_empty && i_bank_data_valid) begin
            err_q <= 1'b1;
         end
      end
   end

   // Tag storage carries no reset; only entries between the pointers are ever read.
   always_ff @(posedge i_clk) begin
      if (push) begin
         tag_mem_q[wr_ptr_q] <= grant_idx;
      end
   end

   assign o_type_valid   = out_valid_q;
   assign o_request_type = out_type_q;
   assign o_addr         = out_addr_q;
   assign o_data         = out_data_q;
   assign o_tags_pending = count_q;
   assign o_err_orphan   = err_q;

endmodule

// File: tb/tb_fiber_pe_arbiter.sv
// Directed bench for fiber_pe_arbiter: a queue-based reference model checked every cycle,
// plus hand-computed expectations for reset, round robin, backpressure, tag-full, routing and orphan.
module tb_fiber_pe_arbiter;

   localparam int          NUM_PE = 4;
   localparam int          DW     = 16;
   localparam int          AW     = 64;
   localparam int          TD     = 8;
   localparam logic [15:0] MASK   = 16'h0006;

   logic                  i_clk = 1'b0;
   logic                  i_nreset;
   logic [NUM_PE-1:0]     i_pe_req_valid;
   logic [NUM_PE*4-1:0]   i_pe_req_type;
   logic [NUM_PE*AW-1:0]  i_pe_req_addr;
   logic [NUM_PE*DW-1:0]  i_pe_req_data;
   logic [NUM_PE-1:0]     o_pe_req_ready;
   logic [3:0]            o_request_type;
   logic [AW-1:0]         o_addr;
   logic [DW-1:0]         o_data;
   logic                  o_type_valid;
   logic                  i_type_ready;
   logic [DW-1:0]         i_bank_data;
   logic                  i_bank_data_valid;
   logic                  o_bank_data_ready;
   logic [DW-1:0]         o_pe_resp_data;
   logic [NUM_PE-1:0]     o_pe_resp_valid;
   logic [NUM_PE-1:0]     i_pe_resp_ready;
   logic [3:0]            o_tags_pending;
   logic                  o_err_orphan;

   int checks = 0;
   int errors = 0;

   fiber_pe_arbiter #(
      .NUM_PE(NUM_PE), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_DEPTH(TD), .RESP_MASK(MASK)
   ) dut (
      .i_clk(i_clk), .i_nreset(i_nreset),
      .i_pe_req_valid(i_pe_req_valid), .i_pe_req_type(i_pe_req_type),
      .i_pe_req_addr(i_pe_req_addr), .i_pe_req_data(i_pe_req_data),
      .o_pe_req_ready(o_pe_req_ready), .o_request_type(o_request_type),
      .o_addr(o_addr), .o_data(o_data), .o_type_valid(o_type_valid),
      .i_type_ready(i_type_ready), .i_bank_data(i_bank_data),
      .i_bank_data_valid(i_bank_data_valid), .o_bank_data_ready(o_bank_data_ready),
      .o_pe_resp_data(o_pe_resp_data), .o_pe_resp_valid(o_pe_resp_valid),
      .i_pe_resp_ready(i_pe_resp_ready), .o_tags_pending(o_tags_pending),
      .o_err_orphan(o_err_orphan)
   );

   // ---------------- clock ----------------
   always #5 i_clk = ~i_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] pe_type(input int k);
      return i_pe_req_type[4*k +: 4];
   endfunction

   // ---------------- reference model ----------------
   logic              m_full = 1'b0;
   logic [3:0]        m_type = '0;
   logic [AW-1:0]     m_addr = '0;
   logic [DW-1:0]     m_data = '0;
   int                m_ptr  = NUM_PE - 1;
   logic              m_orphan = 1'b0;
   logic [3:0]        exp_q[$];
   int                g, kk, h;
   logic              m_slot_free;
   logic [NUM_PE-1:0] e_ready, e_rvalid;
   logic              e_bready;

   always @(negedge i_clk) begin
      if (!i_nreset) begin
         chk("m_rst_ready", o_pe_req_ready, '0);
         chk("m_rst_type_valid", o_type_valid, 1'b0);
         chk("m_rst_tags", o_tags_pending, '0);
         chk("m_rst_err", o_err_orphan, 1'b0);
         chk("m_rst_resp_valid", o_pe_resp_valid, '0);
         chk("m_rst_bank_ready", o_bank_data_ready, 1'b0);
         m_full = 1'b0;
         m_ptr = NUM_PE - 1;
         m_orphan = 1'b0;
         exp_q.delete();
      end else begin
         m_slot_free = !m_full || i_type_ready;
         g = -1;
         if (m_slot_free) begin
            for (int i = 1; i <= NUM_PE; i++) begin
               kk = (m_ptr + i) % NUM_PE;
               if (g < 0 && i_pe_req_valid[kk] && (!MASK[pe_type(kk)] || exp_q.size() < TD)) g = kk;
            end
         end
         e_ready = '0;
         if (g >= 0) e_ready[g] = 1'b1;
         e_rvalid = '0;
         e_bready = 1'b0;
         if (exp_q.size() > 0) begin
            h = int'(exp_q[0]);
            e_rvalid[h] = i_bank_data_valid;
            e_bready = i_pe_resp_ready[h];
         end
         chk("m_req_ready", o_pe_req_ready, e_ready);
         chk("m_type_valid", o_type_valid, m_full);
         if (m_full) begin
            chk("m_req_type", o_request_type, m_type);
            chk("m_addr", o_addr, m_addr);
            chk("m_data", o_data, m_data);
         end
         chk("m_tags", o_tags_pending, exp_q.size());
         chk("m_err", o_err_orphan, m_orphan);
         chk("m_resp_valid", o_pe_resp_valid, e_rvalid);
         chk("m_bank_ready", o_bank_data_ready, e_bready);
         chk("m_resp_data", o_pe_resp_data, i_bank_data);
         // state after the coming rising edge
         if (exp_q.size() == 0 && i_bank_data_valid) m_orphan = 1'b1;
         if (exp_q.size() > 0 && i_bank_data_valid && e_bready) void'(exp_q.pop_front());
         if (g >= 0) begin
            if (MASK[pe_type(g)]) exp_q.push_back(4'(g));
            m_type = pe_type(g);
            m_addr = i_pe_req_addr[AW*g +: AW];
            m_data = i_pe_req_data[DW*g +: DW];
            m_ptr  = g;
         end
         if (m_slot_free) m_full = (g >= 0);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge i_clk);
   endtask

   task automatic set_req(input int k, input logic v, input logic [3:0] t,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
      i_pe_req_valid[k]        = v;
      i_pe_req_type[4*k +: 4]  = t;
      i_pe_req_addr[AW*k +: AW] = a;
      i_pe_req_data[DW*k +: DW] = d;
   endtask

   task automatic flush_tags();
      int guard;
      guard = 0;
      i_pe_resp_ready = '1;
      while (exp_q.size() > 0 && guard < 40) begin
         i_bank_data       = DW'($urandom_range(0, 16'hFFFF));
         i_bank_data_valid = 1'b1;
         tick();
         guard++;
      end
      i_bank_data_valid = 1'b0;
      chk("flush_bound", guard < 40, 1'b1);
      at_neg();
      chk("flush_empty", o_tags_pending, 0);
      tick();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      i_nreset = 1'b0;
      i_pe_req_valid = '0;
      i_pe_req_type = '0;
      i_pe_req_addr = '0;
      i_pe_req_data = '0;
      i_type_ready = 1'b1;
      i_bank_data = '0;
      i_bank_data_valid = 1'b0;
      i_pe_resp_ready = '1;

      // reset held while every PE requests, then round robin
      for (int k = 0; k < NUM_PE; k++) set_req(k, 1'b1, 4'd1, 64'(16 * (k + 1)), 16'(16'hD000 + k));
      repeat (3) begin
         at_neg();
         chk("rst_ready", o_pe_req_ready, 4'b0000);
         chk("rst_type_valid", o_type_valid, 1'b0);
         chk("rst_tags", o_tags_pending, 0);
         chk("rst_err", o_err_orphan, 1'b0);
      end
      tick();
      i_nreset = 1'b1;
      at_neg();
      chk("first_grant", o_pe_req_ready, 4'b0001);
      tick();
      for (int i = 0; i < 5; i++) begin
         at_neg();
         chk("rr_addr", o_addr, 64'(16 * ((i % 4) + 1)));
         chk("rr_valid", o_type_valid, 1'b1);
         chk("rr_tags", o_tags_pending, i + 1);
         tick();
      end
      i_pe_req_valid = '0;
      flush_tags();

      // backpressure: pointer sits on PE1, so PE2 wins first, PE0 on the drain cycle
      set_req(0, 1'b1, 4'd0, 64'h100, 16'h1111);
      set_req(2, 1'b1, 4'd0, 64'h300, 16'h3333);
      i_type_ready = 1'b0;
      at_neg();
      chk("bp_grant", o_pe_req_ready, 4'b0100);
      tick();
      repeat (5) begin
         at_neg();
         chk("bp_addr", o_addr, 64'h300);
         chk("bp_type", o_request_type, 4'd0);
         chk("bp_data", o_data, 16'h3333);
         chk("bp_ready", o_pe_req_ready, 4'b0000);
         tick();
      end
      i_type_ready = 1'b1;
      at_neg();
      chk("bp_drain_grant", o_pe_req_ready, 4'b0001);
      tick();
      at_neg();
      chk("bp_next_addr", o_addr, 64'h100);
      tick();
      i_pe_req_valid = '0;
      tick();
      tick();

      // tag FIFO full
      set_req(2, 1'b1, 4'd1, 64'h2000, 16'h2222);
      for (int i = 0; i < 8; i++) begin
         at_neg();
         chk("fill_ready", o_pe_req_ready, 4'b0100);
         tick();
      end
      i_pe_req_valid[2] = 1'b0;
      set_req(1, 1'b1, 4'd1, 64'h1000, 16'h1234);
      set_req(3, 1'b1, 4'd0, 64'h3000, 16'h4321);
      at_neg();
      chk("full_tags", o_tags_pending, 8);
      chk("full_write_granted", o_pe_req_ready, 4'b1000);
      tick();
      i_pe_req_valid[3] = 1'b0;
      at_neg();
      chk("full_hold", o_pe_req_ready, 4'b0000);
      tick();
      i_bank_data = 16'h5555;
      i_bank_data_valid = 1'b1;
      at_neg();
      chk("pop_same_cycle", o_pe_req_ready, 4'b0000);
      chk("pop_resp_valid", o_pe_resp_valid, 4'b0100);
      tick();
      i_bank_data_valid = 1'b0;
      at_neg();
      chk("after_pop_grant", o_pe_req_ready, 4'b0010);
      chk("after_pop_tags", o_tags_pending, 7);
      tick();
      i_pe_req_valid[1] = 1'b0;
      flush_tags();

      // response routing PE3, PE0, PE3
      set_req(3, 1'b1, 4'd2, 64'hA3, 16'h0003);
      at_neg(); chk("rt_g0", o_pe_req_ready, 4'b1000); tick();
      i_pe_req_valid[3] = 1'b0;
      set_req(0, 1'b1, 4'd2, 64'hA0, 16'h0000);
      at_neg(); chk("rt_g1", o_pe_req_ready, 4'b0001); tick();
      i_pe_req_valid[0] = 1'b0;
      set_req(3, 1'b1, 4'd2, 64'hA3, 16'h0003);
      at_neg(); chk("rt_g2", o_pe_req_ready, 4'b1000); tick();
      i_pe_req_valid[3] = 1'b0;
      at_neg(); chk("rt_tags", o_tags_pending, 3); tick();
      i_pe_resp_ready = 4'b1110;
      i_bank_data = 16'hAAAA;
      i_bank_data_valid = 1'b1;
      at_neg();
      chk("rt_b0_valid", o_pe_resp_valid, 4'b1000);
      chk("rt_b0_data", o_pe_resp_data, 16'hAAAA);
      chk("rt_b0_ready", o_bank_data_ready, 1'b1);
      tick();
      i_bank_data = 16'hBBBB;
      repeat (2) begin
         at_neg();
         chk("rt_b1_stall_valid", o_pe_resp_valid, 4'b0001);
         chk("rt_b1_stall_ready", o_bank_data_ready, 1'b0);
         chk("rt_b1_stall_tags", o_tags_pending, 2);
         tick();
      end
      i_pe_resp_ready = 4'b1111;
      at_neg();
      chk("rt_b1_ready", o_bank_data_ready, 1'b1);
      chk("rt_b1_data", o_pe_resp_data, 16'hBBBB);
      tick();
      i_bank_data = 16'hCCCC;
      at_neg();
      chk("rt_b2_valid", o_pe_resp_valid, 4'b1000);
      chk("rt_b2_data", o_pe_resp_data, 16'hCCCC);
      tick();
      i_bank_data_valid = 1'b0;
      at_neg(); chk("rt_done_tags", o_tags_pending, 0); tick();

      // orphan beat, sticky until reset; reset also drops an in-flight request and tag
      i_bank_data = 16'h7777;
      i_bank_data_valid = 1'b1;
      at_neg();
      chk("orph_bank_ready", o_bank_data_ready, 1'b0);
      chk("orph_resp_valid", o_pe_resp_valid, 4'b0000);
      chk("orph_err_before", o_err_orphan, 1'b0);
      tick();
      i_bank_data_valid = 1'b0;
      repeat (3) begin
         at_neg(); chk("orph_err_sticky", o_err_orphan, 1'b1); tick();
      end
      set_req(1, 1'b1, 4'd1, 64'hB0, 16'hBEEF);
      at_neg(); tick();
      at_neg();
      chk("mid_tags", o_tags_pending, 1);
      chk("mid_type_valid", o_type_valid, 1'b1);
      tick();
      i_nreset = 1'b0;
      at_neg();
      chk("rst2_tags", o_tags_pending, 0);
      chk("rst2_type_valid", o_type_valid, 1'b0);
      chk("rst2_err", o_err_orphan, 1'b0);
      tick();
      i_pe_req_valid = '0;
      i_nreset = 1'b1;
      at_neg(); chk("rst2_after_tags", o_tags_pending, 0); tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
